muldiv_sequencer: RTL and testbench

Multi-cycle sequencer for the integer multiply/divide resource (mult, multu, div, divu), which owns the HI/LO result registers.
- Sits beside the EX stage. ID issues an operation with a one-cycle start pulse; the block runs a radix-2 shift-add multiply or restoring divide over WIDTH iterations, then commits HI/LO.
- It raises a combinational stall toward the hazard logic while a dependent mfhi/mflo, or a second mul/div, tries to issue before the result is ready.

---
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle integer multiply/divide sequencer owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_lo_read,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  logic               accept;
  logic               signed_op;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  assign accept    = (state == IDLE) && start && !flush;
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & src_a[WIDTH-1];
  assign b_neg     = signed_op & src_b[WIDTH-1];
  assign mag_a_in  = a_neg ? -src_a : src_a;
  assign mag_b_in  = b_neg ? -src_b : src_b;

  assign stall = busy & (hi_lo_read | start);

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, mag_b};
    acc_next = acc;
    if (!is_div) begin
      if (acc[0]) acc_next = {add_sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end else begin
      // A clear top bit of diff means the trial subtraction did not borrow.
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (!is_div) begin
      {res_hi, res_lo} = neg_res ? -acc : acc;
    end else if (div_zero) begin
      // Re-applying the dividend sign to its magnitude reproduces src_a exactly.
      res_hi = neg_rem ? -mag_a : mag_a;
      res_lo = '1;
    end else begin
      res_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  // NOTE: datapath registers carry no reset; they are always loaded on accept before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div   <= op[1];
      neg_res  <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
      div_zero <= op[1] & (src_b == '0);
      mag_a    <= mag_a_in;
      mag_b    <= mag_b_in;
      acc      <= {{WIDTH{1'b0}}, (op[1] ? mag_a_in : mag_b_in)};
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            count <= count + 1'b1;
            if (count == LAST_ITER) state <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// stall/flush/reset sequences, and random ops against an arithmetic model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_lo_read;
  logic        flush;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .hi_lo_read (hi_lo_read),
    .flush      (flush),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p  = '0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'h0, a} * {32'h0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic hl, input int mid);
    int k, busy_n, stall_bad;
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; hi_lo_read = hl;
    k = 0; busy_n = 0; stall_bad = 0;
    while (!done && k < 60) begin
      busy_n += int'(busy);
      if (k == mid) begin
        start = 1'b1; op = 2'b01; src_a = 32'h0000_1234; src_b = 32'h0000_0003;
      end
      #1;
      if ((hl || k == mid) && stall !== 1'b1) stall_bad++;
      @(negedge clk);
      start = 1'b0;
      k++;
    end
    check({name, " latency"}, 64'(k), 64'd33);
    check({name, " busy cycles"}, 64'(busy_n), 64'd33);
    check({name, " stall while busy"}, 64'(stall_bad), 64'd0);
    check({name, " done-cycle busy/stall"}, {62'd0, busy, stall}, 64'd0);
    check({name, " hi"}, 64'(hi), 64'(exp_hi));
    check({name, " lo"}, 64'(lo), 64'(exp_lo));
    hi_lo_read = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  vec_t        vecs[8];
  logic [63:0] exp;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  int          done_seen;

  initial begin
    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[6] = '{2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};

    reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; hi_lo_read = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset state", {busy, done, stall, hi, lo}, '0);
    reset = 1'b0; hi_lo_read = 1'b0;
    @(negedge clk);

    // Directed table, each op issued in the done cycle of the previous one.
    for (int i = 0; i < 8; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, -1);
    @(negedge clk);
    check("done pulse width", {62'd0, done, busy}, 64'd0);

    // Stall held by mfhi/mflo, plus a start pulse mid-run that must be ignored.
    do_op("stall", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, 12);
    @(negedge clk);
    check("mid-run start ignored", {63'd0, busy}, 64'd0);

    // start and flush together in IDLE accept nothing.
    op = 2'b01; src_a = 32'd3; src_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("start+flush idle", {63'd0, busy}, 64'd0);

    // Flush at iteration 10 keeps the old HI/LO.
    op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy/done", {62'd0, busy, done}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      done_seen += int'(done | busy);
    end
    check("flush no done", 64'(done_seen), 64'd0);
    check("flush hi/lo kept", {hi, lo}, {32'd2, 32'd14});

    // Reset at iteration 10 clears everything.
    op = 2'b00; src_a = 32'd9; src_b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-op reset", {busy, done, hi, lo}, '0);
    @(negedge clk);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = pick();
      rb  = pick();
      exp = model(rop, ra, rb);
      do_op($sformatf("rand%0d op%0d %h %h", i, rop, ra, rb), rop, ra, rb, exp[63:32], exp[31:0], 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
